// File: rtl/gf_mult_arbiter.sv
// gf_mult_arbiter
// Round-robin arbiter that shares one combinational GF(2^m) multiplier among
// NUM_REQ requesters (syndrome, key-equation, Chien units of the BCH decoder).
// The winner's operands are masked to the field width, multiplied, and the
// product is captured in a single registered response slot tagged with the
// requester index.
//
// Ports
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_req_valid      : per-requester request valid
//   i_req_a/b        : 10-bit operands, requester k at [10k+9:10k]
//   i_req_code       : 2-bit field code (0=GF(2^6), 1=GF(2^8), 2=GF(2^10), 3=illegal)
//   o_req_ready      : one-hot grant (or zero), accept on valid & ready
//   o_rsp_valid      : response slot full
//   o_rsp_id         : requester index of the response
//   o_rsp_product    : product, zero-extended above m bits
//   o_rsp_err        : response came from an illegal code
//   i_rsp_ready      : consumer drains the response
//   o_grant_cnt      : per-requester 16-bit saturating grant counters
//
// Build option
//   GF_MULT_ARB_STATS_EN : when defined, builds the grant counters; otherwise
//                          o_grant_cnt is tied to zero.

module gf_mult_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NUM_REQ-1:0]    i_req_valid,
    input  logic [10*NUM_REQ-1:0] i_req_a,
    input  logic [10*NUM_REQ-1:0] i_req_b,
    input  logic [2*NUM_REQ-1:0]  i_req_code,
    output logic [NUM_REQ-1:0]    o_req_ready,
    output logic                  o_rsp_valid,
    output logic [ID_W-1:0]       o_rsp_id,
    output logic [9:0]            o_rsp_product,
    output logic                  o_rsp_err,
    input  logic                  i_rsp_ready,
    output logic [16*NUM_REQ-1:0] o_grant_cnt
);

    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // Operand mask for the field selected by code; illegal code masks everything.
    function automatic logic [9:0] field_mask(input logic [1:0] code);
        logic [9:0] m;
        case (code)
            2'd0:    m = 10'h03F;
            2'd1:    m = 10'h0FF;
            2'd2:    m = 10'h3FF;
            default: m = 10'h000;
        endcase
        return m;
    endfunction

    // Shift-and-add GF multiply; the running multiple of a is reduced by the
    // field polynomial (x^6+x+1, x^8+x^4+x^3+x^2+1, x^10+x^3+1) each step.
    function automatic logic [9:0] gf_mult(input logic [9:0] a, input logic [9:0] b,
                                           input logic [1:0] code);
        logic [9:0] acc;
        logic [9:0] sh;
        logic [9:0] msk;
        logic [9:0] top;
        logic [9:0] poly;
        case (code)
            2'd0:    begin msk = 10'h03F; top = 10'h020; poly = 10'h003; end
            2'd1:    begin msk = 10'h0FF; top = 10'h080; poly = 10'h01D; end
            2'd2:    begin msk = 10'h3FF; top = 10'h200; poly = 10'h009; end
            default: begin msk = 10'h000; top = 10'h000; poly = 10'h000; end
        endcase
        acc = 10'h000;
        sh  = a & msk;
        for (int i = 0; i < 10; i++) begin
            if (b[i]) acc = acc ^ sh;
            else      acc = acc;
            if ((sh & top) != 10'h000) sh = ((sh << 1) & msk) ^ poly;
            else                       sh = (sh << 1) & msk;
        end
        return acc;
    endfunction

    slot_state_t       state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [9:0]        rsp_product_q, rsp_product_d;
    logic              rsp_err_q, rsp_err_d;

    logic [NUM_REQ-1:0] rot_s;
    logic [ID_W-1:0]    off_s;
    logic [ID_W:0]      sum_s;
    logic [ID_W-1:0]    win_s;
    logic [ID_W-1:0]    ptr_nxt_s;
    logic               can_accept_s;
    logic               accept_s;
    logic [9:0]         sel_a_s;
    logic [9:0]         sel_b_s;
    logic [1:0]         sel_code_s;
    logic [9:0]         mask_s;

    // Round-robin winner: rotate valids so ptr sits at bit 0, find the first
    // set bit, then map the offset back to an absolute index.
    always_comb begin
        rot_s = NUM_REQ'({i_req_valid, i_req_valid} >> ptr_q);
        off_s = {ID_W{1'b0}};
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot_s[k]) off_s = ID_W'(k);
            else          off_s = off_s;
        end
        sum_s = {1'b0, ptr_q} + {1'b0, off_s};
        if (sum_s >= (ID_W+1)'(NUM_REQ)) win_s = ID_W'(sum_s - (ID_W+1)'(NUM_REQ));
        else                             win_s = sum_s[ID_W-1:0];
        if (win_s == ID_W'(NUM_REQ - 1)) ptr_nxt_s = {ID_W{1'b0}};
        else                             ptr_nxt_s = win_s + {{(ID_W-1){1'b0}}, 1'b1};
    end

    // Grant generation; held off while in reset so nothing looks accepted.
    always_comb begin
        can_accept_s = (state_q == SLOT_EMPTY) | i_rsp_ready;
        accept_s     = (|i_req_valid) & can_accept_s & i_rst_n;
        if (accept_s) o_req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_s;
        else          o_req_ready = {NUM_REQ{1'b0}};
    end

    // Operand mux for the winner; the only path from operands to the slot.
    always_comb begin
        sel_a_s    = 10'h000;
        sel_b_s    = 10'h000;
        sel_code_s = 2'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win_s == ID_W'(k)) begin
                sel_a_s    = i_req_a[10*k +: 10];
                sel_b_s    = i_req_b[10*k +: 10];
                sel_code_s = i_req_code[2*k +: 2];
            end else begin
                sel_a_s    = sel_a_s;
                sel_b_s    = sel_b_s;
                sel_code_s = sel_code_s;
            end
        end
        mask_s = field_mask(sel_code_s);
    end

    // Slot and pointer next state: load on accept, drain to EMPTY otherwise.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        rsp_id_d      = rsp_id_q;
        rsp_product_d = rsp_product_q;
        rsp_err_d     = rsp_err_q;
        if (accept_s) begin
            state_d       = SLOT_FULL;
            ptr_d         = ptr_nxt_s;
            rsp_id_d      = win_s;
            rsp_product_d = gf_mult(sel_a_s & mask_s, sel_b_s & mask_s, sel_code_s);
            rsp_err_d     = (sel_code_s == 2'd3);
        end else if (i_rsp_ready) begin
            state_d = SLOT_EMPTY;
        end else begin
            state_d = state_q;
        end
    end

    // Slot state machine and response registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= SLOT_EMPTY;
            ptr_q         <= {ID_W{1'b0}};
            rsp_id_q      <= {ID_W{1'b0}};
            rsp_product_q <= 10'h000;
            rsp_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            rsp_id_q      <= rsp_id_d;
            rsp_product_q <= rsp_product_d;
            rsp_err_q     <= rsp_err_d;
        end
    end

    assign o_rsp_valid   = (state_q == SLOT_FULL);
    assign o_rsp_id      = rsp_id_q;
    assign o_rsp_product = rsp_product_q;
    assign o_rsp_err     = rsp_err_q;

`ifdef GF_MULT_ARB_STATS_EN
    logic [15:0] cnt_q [NUM_REQ];
    logic [15:0] cnt_d [NUM_REQ];

    // Saturating grant counter per requester.
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            if (accept_s && (win_s == ID_W'(k)) && (cnt_q[k] != 16'hFFFF)) cnt_d[k] = cnt_q[k] + 16'd1;
            else                                                           cnt_d[k] = cnt_q[k];
        end
    end

    // Grant counter registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NUM_REQ; k++) cnt_q[k] <= 16'h0000;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) cnt_q[k] <= cnt_d[k];
        end
    end

    // Pack the counters onto the output bus.
    always_comb begin
        o_grant_cnt = {(16*NUM_REQ){1'b0}};
        for (int k = 0; k < NUM_REQ; k++) o_grant_cnt[16*k +: 16] = cnt_q[k];
    end
`else
    assign o_grant_cnt = {(16*NUM_REQ){1'b0}};
`endif

endmodule

// File: tb/tb_gf_mult_arbiter.sv
// Bench for gf_mult_arbiter: a negedge monitor models arbitration and the
// slot, pushes expected responses into a queue on each accept and pops and
// compares them when the slot loads; directed sequences cover the test plan.

module tb_gf_mult_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                  clk       = 1'b0;
    logic                  rst_n     = 1'b0;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [10*NUM_REQ-1:0] req_a     = '0;
    logic [10*NUM_REQ-1:0] req_b     = '0;
    logic [2*NUM_REQ-1:0]  req_code  = '0;
    logic                  rsp_ready = 1'b1;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  rsp_valid;
    logic [ID_W-1:0]       rsp_id;
    logic [9:0]            rsp_product;
    logic                  rsp_err;
    logic [16*NUM_REQ-1:0] grant_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    gf_mult_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (req_valid),
        .i_req_a      (req_a),
        .i_req_b      (req_b),
        .i_req_code   (req_code),
        .o_req_ready  (req_ready),
        .o_rsp_valid  (rsp_valid),
        .o_rsp_id     (rsp_id),
        .o_rsp_product(rsp_product),
        .o_rsp_err    (rsp_err),
        .i_rsp_ready  (rsp_ready),
        .o_grant_cnt  (grant_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference multiply: carry-less product, then long division by the full
    // field polynomial.
    function automatic logic [9:0] ref_gf(input logic [9:0] a, input logic [9:0] b, input logic [1:0] code);
        logic [19:0] p;
        logic [19:0] poly;
        logic [9:0]  am;
        logic [9:0]  bm;
        int          m;
        case (code)
            2'd0:    begin m = 6;  poly = 20'h00043; end
            2'd1:    begin m = 8;  poly = 20'h0011D; end
            2'd2:    begin m = 10; poly = 20'h00409; end
            default: begin m = 0;  poly = 20'h00000; end
        endcase
        if (m == 0) return 10'h000;
        am = a & 10'((1 << m) - 1);
        bm = b & 10'((1 << m) - 1);
        p = 20'h00000;
        for (int i = 0; i < 10; i++) if (bm[i]) p = p ^ (20'(am) << i);
        for (int i = 19; i >= m; i--) if (p[i]) p = p ^ (poly << (i - m));
        return p[9:0];
    endfunction

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [9:0]      prod;
        logic            err;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t slot_m;
    logic full_m = 1'b0;
    logic pend_m = 1'b0;
    int   ptr_m  = 0;
    int   cnt_m[NUM_REQ];

    // Scoreboard monitor: model arbitration, push on accept, pop on load.
    always @(negedge clk) begin : monitor
        logic [NUM_REQ-1:0] exp_rdy;
        logic               can;
        int                 w;
        int                 idx;
        if (!rst_n) begin
            exp_q.delete();
            full_m = 1'b0;
            pend_m = 1'b0;
            ptr_m  = 0;
            for (int k = 0; k < NUM_REQ; k++) cnt_m[k] = 0;
        end else begin
            if (pend_m) begin
                if (exp_q.size() == 0) check_eq("sb_underflow", 32'd0, 32'd1);
                else begin
                    slot_m = exp_q.pop_front();
                    full_m = 1'b1;
                end
            end
            check_eq("mon_rsp_valid", rsp_valid, full_m);
            if (full_m) begin
                check_eq("mon_rsp_id", rsp_id, slot_m.id);
                check_eq("mon_rsp_product", rsp_product, slot_m.prod);
                check_eq("mon_rsp_err", rsp_err, slot_m.err);
            end
            for (int k = 0; k < NUM_REQ; k++) begin
`ifdef GF_MULT_ARB_STATS_EN
                check_eq("mon_grant_cnt", grant_cnt[16*k +: 16], cnt_m[k]);
`else
                check_eq("mon_grant_cnt", grant_cnt[16*k +: 16], 32'd0);
`endif
            end
            can     = !full_m || rsp_ready;
            exp_rdy = '0;
            w       = -1;
            if (can) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    idx = (ptr_m + i) % NUM_REQ;
                    if (w < 0 && req_valid[idx]) begin
                        w = idx;
                        exp_rdy[idx] = 1'b1;
                    end
                end
            end
            check_eq("mon_req_ready", req_ready, exp_rdy);
            pend_m = 1'b0;
            if (w >= 0) begin
                exp_q.push_back('{id:   ID_W'(w),
                                  prod: ref_gf(req_a[10*w +: 10], req_b[10*w +: 10], req_code[2*w +: 2]),
                                  err:  (req_code[2*w +: 2] == 2'd3)});
                ptr_m = (w + 1) % NUM_REQ;
                if (cnt_m[w] < 65535) cnt_m[w]++;
                pend_m = 1'b1;
            end else if (rsp_ready) begin
                full_m = 1'b0;
            end
        end
    end

    // Raise one request, wait (bounded) for its grant, then drop valid.
    task automatic do_req(input int k, input logic [9:0] a, input logic [9:0] b, input logic [1:0] code);
        logic ok;
        req_valid[k]          = 1'b1;
        req_a[10*k +: 10]     = a;
        req_b[10*k +: 10]     = b;
        req_code[2*k +: 2]    = code;
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (req_ready[k]) ok = 1'b1;
            @(posedge clk); #1;
        end
        req_valid[k] = 1'b0;
        check_eq("grant_seen", ok, 1'b1);
    endtask

    logic [ID_W-1:0] cap_id;
    logic [9:0]      cap_prod;
    logic            cap_err;
    logic [3:0]      exp_v;

    initial begin
        // Reset values (valid raised to show grants are held off in reset)
        req_valid = 4'b0001;
        @(posedge clk); #1;
        check_eq("rst_rsp_valid", rsp_valid, 1'b0);
        check_eq("rst_rsp_id", rsp_id, 2'd0);
        check_eq("rst_rsp_product", rsp_product, 10'h000);
        check_eq("rst_rsp_err", rsp_err, 1'b0);
        check_eq("rst_req_ready", req_ready, 4'b0000);
        check_eq("rst_grant_cnt", grant_cnt, 64'd0);
        req_valid = 4'b0000;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_req(0, 10'h002, 10'h020, 2'd0);
        check_eq("m6_valid", rsp_valid, 1'b1);
        check_eq("m6_id", rsp_id, 2'd0);
        check_eq("m6_product", rsp_product, 10'h003);
        check_eq("m6_err", rsp_err, 1'b0);

        do_req(2, 10'h080, 10'h002, 2'd1);
        check_eq("m8_id", rsp_id, 2'd2);
        check_eq("m8_product", rsp_product, 10'h01D);

        do_req(3, 10'h200, 10'h002, 2'd2);
        check_eq("m10_id", rsp_id, 2'd3);
        check_eq("m10_product", rsp_product, 10'h009);

        do_req(1, 10'h3C2, 10'h3E0, 2'd0);
        check_eq("mask_product", rsp_product, 10'h003);

        do_req(1, 10'h155, 10'h0AA, 2'd3);
        check_eq("illegal_product", rsp_product, 10'h000);
        check_eq("illegal_err", rsp_err, 1'b1);
        check_eq("illegal_id", rsp_id, 2'd1);

        // Reset while the slot is full; all requesters are waiting
        for (int k = 0; k < NUM_REQ; k++) begin
            req_a[10*k +: 10]  = 10'($urandom);
            req_b[10*k +: 10]  = 10'($urandom);
            req_code[2*k +: 2] = 2'($urandom_range(0, 3));
        end
        req_valid = 4'b1111;
        check_eq("pre_rst_full", rsp_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_rsp_valid", rsp_valid, 1'b0);
        check_eq("midrst_req_ready", req_ready, 4'b0000);
        check_eq("midrst_grant_cnt", grant_cnt, 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Round-robin from a fresh pointer: 0,1,2,3,0,...
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            exp_v = 4'b0001 << (i % 4);
            check_eq("rr_grant", req_ready, exp_v);
            @(posedge clk); #1;
        end
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef GF_MULT_ARB_STATS_EN
            check_eq("rr_count", grant_cnt[16*k +: 16], 16'd2);
`else
            check_eq("rr_count", grant_cnt[16*k +: 16], 16'd0);
`endif
        end

        // Backpressure: slot full, consumer stalls for 5 cycles
        cap_id    = rsp_id;
        cap_prod  = rsp_product;
        cap_err   = rsp_err;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_req_ready", req_ready, 4'b0000);
            check_eq("bp_rsp_valid", rsp_valid, 1'b1);
            check_eq("bp_rsp_id", rsp_id, cap_id);
            check_eq("bp_rsp_product", rsp_product, cap_prod);
            check_eq("bp_rsp_err", rsp_err, cap_err);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        #1;
        check_eq("bp_release_grant", req_ready, 4'b0001);
        @(posedge clk); #1;
        req_valid = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        check_eq("drained", rsp_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
